// File: rtl/hdmi_tx_pkg.sv
// Shared HDMI transmitter definitions: data-period states, preamble/guard
// lengths, the video preamble control code and the video guard characters.
package hdmi_tx_pkg;

  typedef enum logic [1:0] {
    P_CONTROL  = 2'd0,
    P_PREAMBLE = 2'd1,
    P_GUARD    = 2'd2,
    P_ACTIVE   = 2'd3
  } period_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;

  // {CTL3,CTL2,CTL1,CTL0} during a video preamble: only CTL0 is set.
  localparam logic [3:0] VIDEO_PREAMBLE_CTL = 4'b0001;

  // Leading guard-band characters emitted by the TMDS encoders.
  localparam logic [9:0] VIDEO_GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] VIDEO_GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] VIDEO_GUARD_CH2 = 10'b1011001100;

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with wrap, plus region decode of the
// position that becomes current on the next clock edge.
module video_timing_counter
  import hdmi_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] h_next,
  output logic [11:0] v_next,
  output logic        in_active,
  output logic        in_hsync,
  output logic        in_vsync,
  output logic        in_preamble_win,
  output logic        in_guard_win
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [11:0] PRE_START  = 12'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [11:0] PRE_END    = 12'(H_TOTAL - GUARD_LEN - 1);
  localparam logic [11:0] GRD_START  = 12'(H_TOTAL - GUARD_LEN);

  logic [11:0] h_count_q, v_count_q;
  logic        next_line_active;

  // Next raster position: h wraps every line, v advances on the h wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    h_next = h_count_q + 12'd1;
    v_next = v_count_q;
    if (h_count_q == H_LAST) begin
      h_next = '0;
      v_next = (v_count_q == V_LAST) ? 12'd0 : v_count_q + 12'd1;
    end
  end

  // Counter state; reset parks on the last position so the first edge lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between flops.
    if (rst) begin
      h_count_q <= H_LAST;
      v_count_q <= V_LAST;
    end else begin
      h_count_q <= h_next;
      v_count_q <= v_next;
    end
  end

  // Region decode of the upcoming position, consumed by the output registers.
  always_comb begin
    next_line_active = (v_next == V_LAST) || (v_next < V_ACT_LAST);
    in_active        = (h_next < H_ACT) && (v_next < V_ACT);
    in_hsync         = (h_next >= HS_START) && (h_next < HS_END);
    in_vsync         = (v_next >= VS_START) && (v_next < VS_END);
    in_preamble_win  = next_line_active && (h_next >= PRE_START) && (h_next <= PRE_END);
    in_guard_win     = next_line_active && (h_next >= GRD_START);
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: classifies each pixel cycle as control, video
// preamble, video guard band or active video and drives registered DE,
// channel control bits, guard-band flag, position and frame-start pulse.
// Build option: define HDMI_PERIOD_PREAMBLE_EN for HDMI mode (preamble and
// guard band emitted); otherwise DVI mode (control/active only).
module hdmi_period_scheduler
  import hdmi_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pixelClock,
  input  logic        reset,
  output logic        DE,
  output logic [1:0]  ch0Control,
  output logic [1:0]  ch1Control,
  output logic [1:0]  ch2Control,
  output logic        guardBand,
  output logic [11:0] pixelX,
  output logic [11:0] pixelY,
  output logic        frameStart
);

  logic [11:0] h_next, v_next;
  logic        in_active, in_hsync, in_vsync, in_preamble_win, in_guard_win;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_counter (
    .clk             (pixelClock),
    .rst             (reset),
    .h_next          (h_next),
    .v_next          (v_next),
    .in_active       (in_active),
    .in_hsync        (in_hsync),
    .in_vsync        (in_vsync),
    .in_preamble_win (in_preamble_win),
    .in_guard_win    (in_guard_win)
  );

  period_t     period_d;
  logic        de_d, de_q;
  logic        guard_d, guard_q;
  logic        fs_d, fs_q;
  logic [1:0]  ch0_d, ch0_q;
  logic [1:0]  ch1_d, ch1_q;
  logic [1:0]  ch2_d, ch2_q;
  logic [11:0] x_q, y_q;

`ifndef HDMI_PERIOD_PREAMBLE_EN
  // DVI mode never uses the data-island windows.
  logic unused_windows;
  assign unused_windows = in_preamble_win ^ in_guard_win;
`endif

  // Period classification and next output values for the upcoming position.
  always_comb begin
    period_d = P_CONTROL;
    if (in_active) begin
      period_d = P_ACTIVE;
`ifdef HDMI_PERIOD_PREAMBLE_EN
    end else if (in_guard_win) begin
      period_d = P_GUARD;
    end else if (in_preamble_win) begin
      period_d = P_PREAMBLE;
`endif
    end
    de_d    = (period_d == P_ACTIVE);
    guard_d = (period_d == P_GUARD);
    fs_d    = (h_next == 12'd0) && (v_next == 12'd0);
    ch0_d   = {in_vsync ? SYNC_POL : ~SYNC_POL, in_hsync ? SYNC_POL : ~SYNC_POL};
    ch1_d   = (period_d == P_PREAMBLE) ? VIDEO_PREAMBLE_CTL[1:0] : 2'b00;
    ch2_d   = (period_d == P_PREAMBLE) ? VIDEO_PREAMBLE_CTL[3:2] : 2'b00;
  end

  // Output registers; async reset forces an idle, sync-inactive control period.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      de_q    <= 1'b0;
      guard_q <= 1'b0;
      fs_q    <= 1'b0;
      ch0_q   <= {~SYNC_POL, ~SYNC_POL};
      ch1_q   <= 2'b00;
      ch2_q   <= 2'b00;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      de_q    <= de_d;
      guard_q <= guard_d;
      fs_q    <= fs_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      ch2_q   <= ch2_d;
      x_q     <= h_next;
      y_q     <= v_next;
    end
  end

  assign DE         = de_q;
  assign guardBand  = guard_q;
  assign frameStart = fs_q;
  assign ch0Control = ch0_q;
  assign ch1Control = ch1_q;
  assign ch2Control = ch2_q;
  assign pixelX     = x_q;
  assign pixelY     = y_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler on a small 25x9 raster.
// Expected outputs come from a raster model indexed by cycles since reset.
module tb_hdmi_period_scheduler;

  localparam int H_ACTIVE = 8, H_FRONT = 2, H_SYNC = 3, H_BACK = 12;
  localparam int V_ACTIVE = 4, V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam bit SYNC_POL = 1'b0;
  localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 25
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 9

`ifdef HDMI_PERIOD_PREAMBLE_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  logic        pixelClock = 1'b0;
  logic        reset;
  logic        DE, guardBand, frameStart;
  logic [1:0]  ch0Control, ch1Control, ch2Control;
  logic [11:0] pixelX, pixelY;

  int n_checks = 0;
  int n_errors = 0;
  int k;  // output cycles since reset release

  hdmi_period_scheduler #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(SYNC_POL)
  ) dut (
    .pixelClock (pixelClock),
    .reset      (reset),
    .DE         (DE),
    .ch0Control (ch0Control),
    .ch1Control (ch1Control),
    .ch2Control (ch2Control),
    .guardBand  (guardBand),
    .pixelX     (pixelX),
    .pixelY     (pixelY),
    .frameStart (frameStart)
  );

  always #5 pixelClock = ~pixelClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (k=%0d): got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Observed control bundle {DE,guardBand,frameStart,ch0,ch1,ch2}.
  function automatic logic [31:0] got_ctl();
    return 32'({DE, guardBand, frameStart, ch0Control, ch1Control, ch2Control});
  endfunction

  // Reference: what the outputs must show on output cycle n after release.
  function automatic logic [31:0] exp_ctl(input int n);
    int h, v;
    bit active, hs_on, vs_on, next_active, pre, grd, fs;
    logic [1:0] ch0, ch1;
    h = n % HT;
    v = (n / HT) % VT;
    active      = (h < H_ACTIVE) && (v < V_ACTIVE);
    hs_on       = (h >= H_ACTIVE + H_FRONT) && (h < H_ACTIVE + H_FRONT + H_SYNC);
    vs_on       = (v >= V_ACTIVE + V_FRONT) && (v < V_ACTIVE + V_FRONT + V_SYNC);
    next_active = (v == VT - 1) || (v < V_ACTIVE - 1);
    pre = HDMI && next_active && (h >= HT - 10) && (h <= HT - 3);
    grd = HDMI && next_active && (h >= HT - 2);
    fs  = (h == 0) && (v == 0);
    ch0 = {vs_on ? SYNC_POL : ~SYNC_POL, hs_on ? SYNC_POL : ~SYNC_POL};
    ch1 = pre ? 2'b01 : 2'b00;
    return 32'({active, grd, fs, ch0, ch1, 2'b00});
  endfunction

  function automatic logic [31:0] exp_pos(input int n);
    return {4'd0, 12'((n % HT)), 4'd0, 12'(((n / HT) % VT))};
  endfunction

  task automatic check_reset_state();
    check("rst_ctl", got_ctl(), 32'({3'b000, ~SYNC_POL, ~SYNC_POL, 4'b0000}));
    check("rst_pos", {4'd0, pixelX, 4'd0, pixelY}, 32'd0);
  endtask

  // Advance n cycles, comparing every output cycle against the model.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pixelClock);
      check("ctl", got_ctl(), exp_ctl(k));
      check("pos", {4'd0, pixelX, 4'd0, pixelY}, exp_pos(k));
      k++;
    end
  endtask

  // Assert reset part-way through a cycle, verify the immediate clear, hold, release.
  task automatic pulse_reset(input int offset, input int hold);
    #(offset);
    reset = 1'b1;
    #1;
    check_reset_state();
    for (int i = 0; i < hold; i++) begin
      @(negedge pixelClock);
      check_reset_state();
    end
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    k = 0;
    reset = 1'b1;
    #1;
    check_reset_state();
    repeat (3) @(negedge pixelClock);
    check_reset_state();
    reset = 1'b0;

    // Two full frames plus a little: covers every line type and frameStart spacing.
    run_cycles(2 * HT * VT + 10);

    // Reset in the middle of line 1 at pixelX 18 (inside the preamble window in HDMI mode).
    pulse_reset(0, 2);
    run_cycles(HT + 18 + 1);
    check("mid_pos", {4'd0, pixelX, 4'd0, pixelY}, {4'd0, 12'd18, 4'd0, 12'd1});
    pulse_reset(1, 1);
    run_cycles(HT * VT + 5);

    // Randomly timed resets at arbitrary raster positions.
    for (int r = 0; r < 8; r++) begin
      run_cycles($urandom_range(1, 400));
      pulse_reset($urandom_range(0, 8), $urandom_range(1, 3));
    end
    run_cycles(HT * VT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameters: H_ACTIVE (640, active pixels/line); H_FRONT (16, front porch); H_SYNC (96, hsync width); H_BACK (48, back porch, >= 10); V_ACTIVE (480, active lines); V_FRONT (10); V_SYNC (2); V_BACK (33); SYNC_POL (0, active level of hsync/vsync).
REQ-002 SHALL have ports: pixelClock  in  1  pixel clock, sole clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 DE  out  1  active video, to all three encoder channels.
REQ-005 ch0Control  out  2  {vsync,hsync} for channel 0.
REQ-006 ch1Control  out  2  {CTL1,CTL0} for channel 1.
REQ-007 ch2Control  out  2  {CTL3,CTL2} for channel 2.
REQ-008 guardBand  out  1  video leading guard band in progress; encoders emit guard characters.
REQ-009 pixelX  out  12  horizontal position; pixelY  out  12  vertical position.
REQ-010 frameStart  out  1  one-cycle pulse at (0,0).

Function
REQ-011 H_TOTAL = sum of H_* params; V_TOTAL = sum of V_* params; counters 12-bit unsigned.
REQ-012 hCount increments each pixelClock and wraps H_TOTAL-1 -> 0; on wrap, vCount increments and wraps V_TOTAL-1 -> 0.
REQ-013 Active region: hCount < H_ACTIVE and vCount < V_ACTIVE; then front porch, sync, back porch in that order.
REQ-014 All outputs SHALL be registered: 1 cycle latency from counter state to outputs.
REQ-015 hsync = SYNC_POL when H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC, else ~SYNC_POL; vsync likewise on vCount.
REQ-016 Per-cycle period state: CONTROL, PREAMBLE, GUARD, ACTIVE.
REQ-017 "Next line active" = (vCount == V_TOTAL-1) or (vCount < V_ACTIVE-1).
REQ-018 PREAMBLE when next line active and H_TOTAL-10 <= hCount <= H_TOTAL-3 (8 cycles).
REQ-019 GUARD when next line active and hCount >= H_TOTAL-2 (2 cycles).
REQ-020 ACTIVE in active region; CONTROL otherwise.
REQ-021 PREAMBLE: ch1Control = 2'b01, ch2Control = 2'b00 (CTL0=1, others 0); all other states: ch1Control = ch2Control = 2'b00.
REQ-022 guardBand = 1 only in GUARD; DE = 1 only in ACTIVE; DE and guardBand never both 1.
REQ-023 ch0Control always carries the syncs, including during PREAMBLE/GUARD.
REQ-024 frameStart = 1 for exactly the cycle whose outputs reflect hCount = vCount = 0.
REQ-025 pixelX/pixelY = hCount/vCount of the cycle the outputs describe.

Reset
REQ-026 On reset assertion, immediately: DE, guardBand, frameStart = 0; ch1Control = ch2Control = 0; ch0Control = {~SYNC_POL,~SYNC_POL}; pixelX = pixelY = 0.
REQ-027 Reset SHALL load hCount = H_TOTAL-1 and vCount = V_TOTAL-1, so the first post-release cycle is (0,0).
REQ-028 Mid-frame reset SHALL abort any PREAMBLE/GUARD/ACTIVE with no partial sequence resumed; the first DE after release is at frameStart.

Configuration
REQ-029 Macro HDMI_PERIOD_PREAMBLE_EN: when defined, REQ-018/019/021 apply (HDMI mode).
REQ-030 When undefined: DVI mode; PREAMBLE/GUARD never entered; ch1Control = ch2Control = 0 and guardBand = 0 permanently; DE/syncs identical to HDMI mode.

Structure
REQ-031 Shared package hdmi_tx_pkg: period-state enum (CONTROL/PREAMBLE/GUARD/ACTIVE), PREAMBLE_LEN = 8, GUARD_LEN = 2, video-preamble CTL code, per-channel video guard characters (ch0/ch2 10'b1011001100, ch1 10'b0100110011).
REQ-032 One sub-module, video_timing_counter (hCount/vCount, wrap, region decode); period logic and output registers in the top.

Verification (H: 8/2/3/12, V: 4/1/2/2; H_TOTAL = 25, V_TOTAL = 9; SYNC_POL = 0)
REQ-033 Release reset -> frameStart on the first output cycle, pixelX = pixelY = 0, DE = 1 for 8 cycles, then 0.
REQ-034 Line 0 -> hsync = 0 at pixelX 10..12; PREAMBLE (ch1Control = 01) at pixelX 15..22; guardBand at 23..24; DE at pixelX 0 of line 1.
REQ-035 Line 3 (last active) -> no PREAMBLE/GUARD at its end; vsync = 0 on lines 5..6; PREAMBLE/GUARD on line 8; frameStart repeats every 225 cycles.
REQ-036 Assert reset at line 1, pixelX 18 (mid-preamble) -> outputs reset immediately; after release, next DE only at frameStart.
REQ-037 Build without HDMI_PERIOD_PREAMBLE_EN -> guardBand and ch1/ch2Control stay 0 for a full frame; DE/hsync/vsync match the HDMI-mode trace cycle for cycle.
